uart_rx_frame_collector: RTL and testbench

//  Drains the UART_NUM per-channel RX FIFOs of the pps UART wrapper (pcie_axi_clk side) and packs bytes into
//  32-bit stream beats. One frame per channel burst, closed by MAX_FRAME or idle timeout, ended by a trailer beat.

---
 rtl/uart_rx_collect_pkg.sv | 46 ++++
 rtl/uart_rx_frame_collector_if.sv | 23 ++
 rtl/uart_rx_rr_arbiter.sv | 29 ++
 rtl/uart_rx_frame_collector.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_frame_collector.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_collect_pkg.sv
// Shared types, constants and helpers for the UART RX frame collector.
// The CRC-8 helper is only referenced when UART_RX_FRAME_CRC_EN is defined.
package uart_rx_collect_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [7:0] TRAILER_MAGIC = 8'h5A;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_PUSH,
        ST_TRL
    } state_t;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    // MSB-first CRC-8 step over one byte, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Lane mask for a partially filled pack register (0 means all four lanes).
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [1:0] lanes);
        case (lanes)
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_frame_collector_if.sv
// RX FIFO read side plus 32-bit stream side of the frame collector.
interface uart_rx_frame_collector_if #(
    parameter int unsigned UART_NUM = 6
);
    logic [UART_NUM-1:0]   fifo_uart_rx_empty;
    logic [UART_NUM-1:0]   fifo_uart_rx_rden;
    logic [UART_NUM*8-1:0] uart_rx_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [31:0]           m_data;
    logic [3:0]            m_keep;
    logic                  m_last;

    modport master (
        input  fifo_uart_rx_empty, uart_rx_data, m_ready,
        output fifo_uart_rx_rden, m_valid, m_data, m_keep, m_last
    );

    modport slave (
        output fifo_uart_rx_empty, uart_rx_data, m_ready,
        input  fifo_uart_rx_rden, m_valid, m_data, m_keep, m_last
    );
endinterface

// File: rtl/uart_rx_rr_arbiter.sv
// Combinational round-robin search: first requesting channel at or after rr_ptr, wrapping.
module uart_rx_rr_arbiter #(
    parameter int unsigned N     = 6,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant   = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_collector.sv
// Drains per-channel UART RX FIFOs into 32-bit stream frames closed by a trailer beat.
// Define UART_RX_FRAME_CRC_EN to put a CRC-8 of the payload in trailer[31:24].
module uart_rx_frame_collector
    import uart_rx_collect_pkg::*;
#(
    parameter int unsigned UART_NUM  = 6,
    parameter int unsigned MAX_FRAME = 64
) (
    input  logic                       pcie_axi_clk,
    input  logic                       sys_reset_n,
    input  logic [15:0]                idle_timeout,
    uart_rx_frame_collector_if.master  bus
);

    localparam int unsigned    IDX_W   = (UART_NUM > 1) ? $clog2(UART_NUM) : 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_FRAME);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    lock_q, lock_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [DATA_W-1:0]   pack_q, pack_d;
    logic                closing_q, closing_d;
    logic                valid_q, valid_d;
    beat_t               beat_q, beat_d;
    logic [UART_NUM-1:0] rden_c;

    logic [IDX_W-1:0]    grant;
    logic                any_req;
    logic [7:0]          rx_byte;
    logic [7:0]          magic;
    logic [CNT_W-1:0]    timeout_eff;
    logic [DATA_W-1:0]   trailer;

    uart_rx_rr_arbiter #(
        .N     (UART_NUM),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (~bus.fifo_uart_rx_empty),
        .rr_ptr  (rr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    assign rx_byte     = bus.uart_rx_data[{lock_q, 3'b000} +: 8];
    assign timeout_eff = (idle_timeout == 16'd0) ? 16'd1 : idle_timeout;
    assign trailer     = {magic, 8'(lock_q), byte_cnt_q};

`ifdef UART_RX_FRAME_CRC_EN
    logic [7:0] crc_q, crc_d;

    // Running CRC over the open frame, cleared when a channel is locked.
    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_IDLE && any_req) begin
            crc_d = 8'h00;
        end else if (state_q == ST_CAP) begin
            crc_d = crc8_byte(crc_q, rx_byte);
        end
    end

    always_ff @(posedge pcie_axi_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign magic = crc_q;
`else
    assign magic = TRAILER_MAGIC;
`endif

    always_ff @(posedge pcie_axi_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q    <= ST_IDLE;
            lock_q     <= '0;
            rr_q       <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            pack_q     <= '0;
            closing_q  <= 1'b0;
            valid_q    <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            rr_q       <= rr_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            pack_q     <= pack_d;
            closing_q  <= closing_d;
            valid_q    <= valid_d;
            beat_q     <= beat_d;
        end
    end

    // Next state; the outgoing beat is loaded on entry to PUSH/TRL so it is registered.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        rr_d       = rr_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        pack_d     = pack_q;
        closing_d  = closing_q;
        valid_d    = valid_q;
        beat_d     = beat_q;
        rden_c     = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    lock_d     = grant;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    pack_d     = '0;
                    closing_d  = 1'b0;
                    state_d    = ST_RD;
                end
            end
            ST_RD: begin
                if (!bus.fifo_uart_rx_empty[lock_q]) begin
                    rden_c[lock_q] = 1'b1;
                    idle_cnt_d     = '0;
                    state_d        = ST_CAP;
                end else begin
                    idle_cnt_d = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q : idle_cnt_q + 16'd1;
                    if (idle_cnt_d >= timeout_eff) begin
                        closing_d = 1'b1;
                        valid_d   = 1'b1;
                        if (byte_cnt_q[1:0] != 2'd0) begin
                            beat_d  = '{last: 1'b0, keep: keep_mask(byte_cnt_q[1:0]), data: pack_q};
                            state_d = ST_PUSH;
                        end else begin
                            beat_d  = '{last: 1'b1, keep: 4'hF, data: trailer};
                            state_d = ST_TRL;
                        end
                    end
                end
            end
            ST_CAP: begin
                pack_d[{byte_cnt_q[1:0], 3'b000} +: 8] = rx_byte;
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                if (byte_cnt_q[1:0] == 2'd3 || byte_cnt_d == MAX_LEN) begin
                    closing_d = (byte_cnt_d == MAX_LEN);
                    valid_d   = 1'b1;
                    beat_d    = '{last: 1'b0, keep: 4'hF, data: pack_d};
                    state_d   = ST_PUSH;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_PUSH: begin
                if (bus.m_ready) begin
                    pack_d = '0;
                    if (closing_q) begin
                        beat_d  = '{last: 1'b1, keep: 4'hF, data: trailer};
                        state_d = ST_TRL;
                    end else begin
                        valid_d = 1'b0;
                        beat_d  = '0;
                        state_d = ST_RD;
                    end
                end
            end
            ST_TRL: begin
                if (bus.m_ready) begin
                    valid_d   = 1'b0;
                    beat_d    = '0;
                    closing_d = 1'b0;
                    rr_d      = (lock_q == IDX_W'(UART_NUM - 1)) ? '0 : lock_q + IDX_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.fifo_uart_rx_rden = rden_c;
    assign bus.m_valid           = valid_q;
    assign bus.m_data            = beat_q.data;
    assign bus.m_keep            = beat_q.keep;
    assign bus.m_last            = beat_q.last;

endmodule

// File: tb/tb_uart_rx_frame_collector.sv
// Bench for uart_rx_frame_collector: FIFO models per channel, frame-level expected-beat model.
module tb_uart_rx_frame_collector;

    localparam int N     = 6;
    localparam int MAXF  = 64;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_s;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [15:0] idle_timeout;

    always #5 clk = ~clk;

    uart_rx_frame_collector_if #(.UART_NUM(N)) bus ();

    uart_rx_frame_collector #(
        .UART_NUM  (N),
        .MAX_FRAME (MAXF)
    ) dut (
        .pcie_axi_clk (clk),
        .sys_reset_n  (rst_n),
        .idle_timeout (idle_timeout),
        .bus          (bus)
    );

    // Standard-read FIFOs: data appears the cycle after rden.
    logic [7:0] fmem [N][DEPTH];
    int         fhead [N] = '{default: 0};
    int         ftail [N] = '{default: 0};
    logic [7:0] fdout [N] = '{default: 8'h00};

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.fifo_uart_rx_rden[i] && fhead[i] != ftail[i]) begin
                fdout[i] <= fmem[i][fhead[i] % DEPTH];
                fhead[i] <= fhead[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.fifo_uart_rx_empty[i]  = (fhead[i] == ftail[i]);
            bus.uart_rx_data[8*i +: 8] = fdout[i];
        end
    end

    assign bus.m_ready = ready;

    // Frame-level model state
    logic [7:0] mdat [N][DEPTH];
    int         mhead [N];
    int         mtail [N];
    int         m_rr;
    beat_s      expq [$];
    beat_s      acc_log [$];

    int checks;
    int errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8m(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) begin
            if (r[7]) r = (r << 1) ^ 8'h07;
            else      r = r << 1;
        end
        return r;
    endfunction

    task automatic push_bytes(input int ch, input int first, input int cnt, input bit track);
        logic [7:0] b;
        for (int k = 0; k < cnt; k++) begin
            b = 8'(first + k);
            fmem[ch][ftail[ch] % DEPTH] = b;
            ftail[ch]++;
            if (track) begin
                mdat[ch][mtail[ch] % DEPTH] = b;
                mtail[ch]++;
            end
        end
    endtask

    // Turn all tracked bytes into frames in round-robin order, MAXF bytes max per frame.
    task automatic model_drain();
        int         ch;
        int         n;
        int         fill;
        int         c;
        logic [7:0] crc;
        logic [7:0] b;
        logic [7:0] magic;
        logic [31:0] word;
        bit         more;
        more = 1'b1;
        while (more) begin
            ch = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (ch < 0 && mtail[c] != mhead[c]) ch = c;
            end
            if (ch < 0) begin
                more = 1'b0;
            end else begin
                n = mtail[ch] - mhead[ch];
                if (n > MAXF) n = MAXF;
                crc  = 8'h00;
                word = 32'h0;
                fill = 0;
                for (int k = 0; k < n; k++) begin
                    b = mdat[ch][mhead[ch] % DEPTH];
                    mhead[ch]++;
                    crc = crc8m(crc, b);
                    word[8*fill +: 8] = b;
                    fill++;
                    if (fill == 4 || k == n - 1) begin
                        expq.push_back('{last: 1'b0, keep: 4'((1 << fill) - 1), data: word});
                        word = 32'h0;
                        fill = 0;
                    end
                end
`ifdef UART_RX_FRAME_CRC_EN
                magic = crc;
`else
                magic = 8'h5A;
`endif
                expq.push_back('{last: 1'b1, keep: 4'hF, data: {magic, 8'(ch), 16'(n)}});
                m_rr = (ch + 1) % N;
            end
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int cyc;
        cyc = 0;
        while (expq.size() != 0 && cyc < max_cyc) begin
            @(posedge clk);
            cyc++;
        end
        chk("drain_done", 64'(expq.size()), 64'd0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int cyc;
        cyc = 0;
        while (!bus.m_valid && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(name, 64'(bus.m_valid), 64'd1);
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {27'h0, bus.m_valid, bus.m_last, bus.m_keep, bus.m_data}, 64'h0);
        chk({name, "_rden"}, 64'(bus.fifo_uart_rx_rden), 64'h0);
    endtask

    initial begin
        int    base;
        int    stall_cnt;
        int    head_before;
        bit    stall_prev;
        beat_s prev_beat;
        beat_s act;
        beat_s e;

        checks       = 0;
        errors       = 0;
        m_rr         = 0;
        stall_prev   = 1'b0;
        prev_beat    = '0;
        for (int i = 0; i < N; i++) begin
            mhead[i] = 0;
            mtail[i] = 0;
        end
        rst_n        = 1'b0;
        ready        = 1'b1;
        idle_timeout = 16'd100;

        // Cycle monitor: stream protocol and scoreboard against the model.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    stall_prev = 1'b0;
                end else begin
                    act = '{last: bus.m_last, keep: bus.m_keep, data: bus.m_data};
                    chk("rden_onehot", 64'($countones(bus.fifo_uart_rx_rden) <= 1), 64'd1);
                    if (bus.m_valid) chk("rden_while_valid", 64'(bus.fifo_uart_rx_rden), 64'd0);
                    if (stall_prev) chk("stall_hold", {27'h0, bus.m_valid, act}, {27'h0, 1'b1, prev_beat});
                    if (bus.m_valid && ready) begin
                        if (expq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat: got %h expected none", act);
                        end else begin
                            e = expq.pop_front();
                            chk("beat", 64'(act), 64'(e));
                        end
                        acc_log.push_back(act);
                    end
                    stall_prev = bus.m_valid && !ready;
                    prev_beat  = act;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rst_n = 1'b1;

        // 1: five bytes on ch2, partial last beat
        base = acc_log.size();
        push_bytes(2, 8'h01, 5, 1'b1);
        model_drain();
        wait_drain(2000);
        chk("t1_beat0", 64'(acc_log[base]),     64'({1'b0, 4'hF, 32'h04030201}));
        chk("t1_beat1", 64'(acc_log[base + 1]), 64'({1'b0, 4'h1, 32'h00000005}));
        chk("t1_trl",   64'(acc_log[base + 2]), 64'({1'b1, 4'hF, 32'h5A020005}));

        // 2: 70 bytes on ch0 split at MAX_FRAME
        idle_timeout = 16'd50;
        base = acc_log.size();
        push_bytes(0, 8'h10, 70, 1'b1);
        model_drain();
        wait_drain(4000);
        chk("t2_trl_max", 64'(acc_log[base + 16]), 64'({1'b1, 4'hF, 32'h5A000040}));
        chk("t2_tail",    64'(acc_log[base + 18]), 64'({1'b0, 4'h3, 32'h00005554}));
        chk("t2_trl_6",   64'(acc_log[base + 19]), 64'({1'b1, 4'hF, 32'h5A000006}));

        // 3: round robin after ch1 was served last
        push_bytes(1, 8'hA0, 2, 1'b1);
        model_drain();
        wait_drain(2000);
        base = acc_log.size();
        push_bytes(1, 8'hB0, 2, 1'b1);
        push_bytes(4, 8'hC0, 3, 1'b1);
        model_drain();
        wait_drain(2000);
        chk("t3_ch4_first", 64'(acc_log[base + 1]), 64'({1'b1, 4'hF, 32'h5A040003}));
        chk("t3_ch1_next",  64'(acc_log[base + 3]), 64'({1'b1, 4'hF, 32'h5A010002}));

        // 4: backpressure on a data beat
        @(posedge clk);
        #1;
        ready = 1'b0;
        push_bytes(3, 8'h30, 8, 1'b1);
        model_drain();
        wait_valid("t4_valid_seen", 200);
        head_before = fhead[3];
        stall_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.m_valid) stall_cnt++;
        end
        chk("t4_stall_cycles", 64'(stall_cnt), 64'd20);
        chk("t4_no_read", 64'(fhead[3]), 64'(head_before));
        chk("t4_held_data", 64'({bus.m_keep, bus.m_data}), 64'({4'hF, 32'h33323130}));
        @(posedge clk);
        #1;
        ready = 1'b1;
        wait_drain(2000);

        // 5: reset mid-frame, partial pack then a pending beat
        idle_timeout = 16'd1000;
        push_bytes(5, 8'h50, 3, 1'b0);
        for (int c = 0; c < 500 && fhead[5] != ftail[5]; c++) @(posedge clk);
        chk("t5_bytes_read", 64'(fhead[5]), 64'(ftail[5]));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_reset_partial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b0;
        push_bytes(5, 8'h60, 4, 1'b0);
        wait_valid("t5_pending_seen", 200);
        chk("t5_pending_data", 64'(bus.m_data), 64'h63626160);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_reset_pending");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        m_rr  = 0;
        idle_timeout = 16'd20;
        base = acc_log.size();
        push_bytes(5, 8'h70, 4, 1'b1);
        model_drain();
        wait_drain(2000);
        chk("t5_clean_beat", 64'(acc_log[base]),     64'({1'b0, 4'hF, 32'h73727170}));
        chk("t5_clean_trl",  64'(acc_log[base + 1]), 64'({1'b1, 4'hF, 32'h5A050004}));

        // 6: two bytes on ch0, zero timeout acts as one cycle
        idle_timeout = 16'd0;
        base = acc_log.size();
        push_bytes(0, 8'h01, 2, 1'b1);
        model_drain();
        wait_drain(2000);
        chk("t6_beat", 64'(acc_log[base]), 64'({1'b0, 4'h3, 32'h00000201}));
`ifdef UART_RX_FRAME_CRC_EN
        chk("t6_trl", 64'(acc_log[base + 1]), 64'({1'b1, 4'hF, 32'h1B000002}));
`else
        chk("t6_trl", 64'(acc_log[base + 1]), 64'({1'b1, 4'hF, 32'h5A000002}));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
